// File: rtl/car_park_stim_engine_pkg.sv
// Shared types and constants for the car-park gate stimulus engine.
// Optional abort support is enabled by defining STIM_ABORT_EN.
package car_park_stim_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_P2   = 3'd2,
        ST_P3   = 3'd3,
        ST_P4   = 3'd4,
        ST_GAP  = 3'd5
    } state_e;

    localparam logic DIR_ENTER = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    // Sensor patterns are {a, b}
    localparam logic [1:0] ENTER_P1 = 2'b10;
    localparam logic [1:0] ENTER_P2 = 2'b11;
    localparam logic [1:0] ENTER_P3 = 2'b01;
    localparam logic [1:0] EXIT_P1  = 2'b01;
    localparam logic [1:0] EXIT_P2  = 2'b11;
    localparam logic [1:0] EXIT_P3  = 2'b10;
    localparam logic [1:0] PAT_IDLE = 2'b00;

    function automatic int gate_width(input int num_gates);
        return (num_gates > 1) ? $clog2(num_gates) : 1;
    endfunction

    function automatic logic [1:0] phase_pattern(input state_e st, input logic dir);
        logic [1:0] pat;
        case (st)
            ST_P1:   pat = (dir == DIR_ENTER) ? ENTER_P1 : EXIT_P1;
            ST_P2:   pat = (dir == DIR_ENTER) ? ENTER_P2 : EXIT_P2;
            ST_P3:   pat = (dir == DIR_ENTER) ? ENTER_P3 : EXIT_P3;
            default: pat = PAT_IDLE;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/car_park_stim_engine_if.sv
// Command handshake and sensor/scoreboard bundle of the stimulus engine.
// The abort line exists only when STIM_ABORT_EN is defined.
interface car_park_stim_engine_if #(
    parameter int NUM_GATES = 2,
    parameter int OCC_WIDTH = 4,
    parameter int CNT_WIDTH = 8
);
    import car_park_stim_engine_pkg::*;

    localparam int GATE_W = gate_width(NUM_GATES);

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_dir;
    logic [GATE_W-1:0]    cmd_gate;
    logic [CNT_WIDTH-1:0] cmd_count;
    logic [NUM_GATES-1:0] a;
    logic [NUM_GATES-1:0] b;
    logic                 inc_exp;
    logic                 dec_exp;
    logic [OCC_WIDTH-1:0] exp_occ;
    logic                 sat_err;
    logic                 busy;
    logic                 done;
`ifdef STIM_ABORT_EN
    logic                 abort;
`endif

    modport master (
        output cmd_valid, cmd_dir, cmd_gate, cmd_count,
`ifdef STIM_ABORT_EN
        output abort,
`endif
        input  cmd_ready, a, b, inc_exp, dec_exp, exp_occ, sat_err, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_gate, cmd_count,
`ifdef STIM_ABORT_EN
        input  abort,
`endif
        output cmd_ready, a, b, inc_exp, dec_exp, exp_occ, sat_err, busy, done
    );

endinterface

// File: rtl/car_park_stim_engine_dwell_timer.sv
// Loadable down-counter that flags when a sensor phase has been held long enough.
module car_park_stim_engine_dwell_timer #(
    parameter int DWELL_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic srst_i,
    input  logic load_i,
    output logic expired_o
);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reload on every phase entry, otherwise count down and rest at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(DWELL_CYCLES - 1);
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CW{1'b0}};
        end else if (srst_i) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/car_park_stim_engine.sv
// Command-driven car-park gate sensor pattern generator with expected-occupancy tracking.
// Define STIM_ABORT_EN to add an abort input that terminates a running command.
module car_park_stim_engine
    import car_park_stim_engine_pkg::*;
#(
    parameter int NUM_GATES    = 2,
    parameter int DWELL_CYCLES = 1,
    parameter int OCC_WIDTH    = 4,
    parameter int MAX_OCC      = 15,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  srst_i,
    car_park_stim_engine_if.slave bus
);
    localparam int                   GATE_W      = gate_width(NUM_GATES);
    localparam logic [31:0]          NUM_GATES_U = 32'(NUM_GATES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [OCC_WIDTH-1:0] OCC_MAX     = OCC_WIDTH'(MAX_OCC);

    state_e               state_q, state_d;
    logic                 dir_q, dir_d;
    logic [GATE_W-1:0]    gate_q, gate_d;
    logic [CNT_WIDTH-1:0] cars_q, cars_d;
    logic [OCC_WIDTH-1:0] occ_q, occ_d;
    logic [NUM_GATES-1:0] a_q, a_d, b_q, b_d;
    logic                 inc_q, inc_d, dec_q, dec_d, sat_q, sat_d;
    logic                 done_q, done_d, ready_q, busy_q;
    logic                 accept_s, noop_s, abort_s, expired_s, load_s, car_done_s;
    logic [1:0]           pat_s;

`ifdef STIM_ABORT_EN
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif

    assign accept_s = bus.cmd_valid && (state_q == ST_IDLE);
    assign noop_s   = (bus.cmd_count == {CNT_WIDTH{1'b0}}) ||
                      (32'(bus.cmd_gate) >= NUM_GATES_U);
    assign dir_d    = accept_s ? bus.cmd_dir  : dir_q;
    assign gate_d   = accept_s ? bus.cmd_gate : gate_q;
    assign load_s   = (state_d != state_q);

    car_park_stim_engine_dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .srst_i    (srst_i),
        .load_i    (load_s),
        .expired_o (expired_s)
    );

    // Phase sequencing; an abort overrides whatever phase is in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = (accept_s && !noop_s) ? ST_P1 : ST_IDLE;
            ST_P1:   state_d = expired_s ? ST_P2 : ST_P1;
            ST_P2:   state_d = expired_s ? ST_P3 : ST_P2;
            ST_P3:   state_d = expired_s ? ST_P4 : ST_P3;
            ST_P4:   state_d = expired_s ? ST_GAP : ST_P4;
            ST_GAP:  state_d = (cars_q > CNT_ONE) ? ST_P1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_s && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Remaining-car counter, loaded at accept and consumed at each gap
    always_comb begin
        cars_d = cars_q;
        if (accept_s) begin
            cars_d = bus.cmd_count;
        end else if ((state_q == ST_GAP) && (state_d == ST_P1)) begin
            cars_d = cars_q - CNT_ONE;
        end else begin
            cars_d = cars_q;
        end
    end

    assign car_done_s = (state_q == ST_P3) && (state_d == ST_P4);

    // Occupancy saturator: count pulses always fire, the value clamps at the bounds
    always_comb begin
        inc_d = 1'b0;
        dec_d = 1'b0;
        sat_d = 1'b0;
        occ_d = occ_q;
        if (car_done_s && (dir_q == DIR_ENTER)) begin
            inc_d = 1'b1;
            if (occ_q >= OCC_MAX) begin
                sat_d = 1'b1;
            end else begin
                occ_d = occ_q + OCC_WIDTH'(1);
            end
        end else if (car_done_s) begin
            dec_d = 1'b1;
            if (occ_q == {OCC_WIDTH{1'b0}}) begin
                sat_d = 1'b1;
            end else begin
                occ_d = occ_q - OCC_WIDTH'(1);
            end
        end else begin
            occ_d = occ_q;
        end
    end

    // Gate demux: only the selected gate sees the pattern
    always_comb begin
        pat_s = phase_pattern(state_d, dir_d);
        a_d   = {NUM_GATES{1'b0}};
        b_d   = {NUM_GATES{1'b0}};
        for (int g = 0; g < NUM_GATES; g++) begin
            a_d[g] = (gate_d == GATE_W'(g)) ? pat_s[1] : 1'b0;
            b_d[g] = (gate_d == GATE_W'(g)) ? pat_s[0] : 1'b0;
        end
    end

    assign done_d = (accept_s && noop_s) || ((state_q != ST_IDLE) && (state_d == ST_IDLE));

    // State, command latch and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_ENTER;
            gate_q  <= {GATE_W{1'b0}};
            cars_q  <= {CNT_WIDTH{1'b0}};
            occ_q   <= {OCC_WIDTH{1'b0}};
            a_q     <= {NUM_GATES{1'b0}};
            b_q     <= {NUM_GATES{1'b0}};
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else if (srst_i) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_ENTER;
            gate_q  <= {GATE_W{1'b0}};
            cars_q  <= {CNT_WIDTH{1'b0}};
            occ_q   <= {OCC_WIDTH{1'b0}};
            a_q     <= {NUM_GATES{1'b0}};
            b_q     <= {NUM_GATES{1'b0}};
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            gate_q  <= gate_d;
            cars_q  <= cars_d;
            occ_q   <= occ_d;
            a_q     <= a_d;
            b_q     <= b_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
            ready_q <= (state_d == ST_IDLE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.inc_exp   = inc_q;
    assign bus.dec_exp   = dec_q;
    assign bus.exp_occ   = occ_q;
    assign bus.sat_err   = sat_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_car_park_stim_engine.sv
// Self-checking bench for car_park_stim_engine: directed scenarios plus random commands
// compared cycle by cycle against a trace model built from the sensor-sequence rules.
module tb_car_park_stim_engine;
    localparam int NG  = 2;
    localparam int DW  = 1;
    localparam int OW  = 4;
    localparam int MX  = 15;
    localparam int CW  = 8;
    localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
    localparam int CAR = 4 * DW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic srst = 1'b0;

    always #5 clk = ~clk;

    car_park_stim_engine_if #(.NUM_GATES(NG), .OCC_WIDTH(OW), .CNT_WIDTH(CW)) bus_if ();

    car_park_stim_engine #(
        .NUM_GATES(NG), .DWELL_CYCLES(DW), .OCC_WIDTH(OW), .MAX_OCC(MX), .CNT_WIDTH(CW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .srst_i (srst),
        .bus    (bus_if.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int model_occ = 0;
    logic [31:0] exp_q[$];
    int          occ_q[$];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] pack(input logic [NG-1:0] a, input logic [NG-1:0] b,
                                         input logic inc, input logic dec, input logic sat,
                                         input logic busy, input logic done, input logic ready,
                                         input int occ);
        logic [OW-1:0] o;
        o = OW'(occ);
        return 32'({a, b, inc, dec, sat, busy, done, ready, o});
    endfunction

    function automatic logic [31:0] observed();
        return pack(bus_if.a, bus_if.b, bus_if.inc_exp, bus_if.dec_exp, bus_if.sat_err,
                    bus_if.busy, bus_if.done, bus_if.cmd_ready, int'(bus_if.exp_occ));
    endfunction

    // Expected per-cycle trace after accept, derived from the sensor-sequence rules
    task automatic build_trace(input logic dir, input int gate, input int count);
        logic [1:0] enter_pat [4];
        logic [1:0] pat;
        logic [NG-1:0] av, bv;
        int occ;
        logic inc, dec, sat;
        enter_pat = '{2'b10, 2'b11, 2'b01, 2'b00};
        exp_q.delete();
        occ_q.delete();
        occ = model_occ;
        if (count != 0 && gate < NG) begin
            for (int car = 0; car < count; car++) begin
                for (int p = 0; p < 4; p++) begin
                    pat = dir ? {enter_pat[p][0], enter_pat[p][1]} : enter_pat[p];
                    av = '0; bv = '0;
                    av[gate] = pat[1];
                    bv[gate] = pat[0];
                    for (int d = 0; d < DW; d++) begin
                        inc = 1'b0; dec = 1'b0; sat = 1'b0;
                        if (p == 3 && d == 0) begin
                            inc = !dir;
                            dec = dir;
                            if (!dir && occ == MX) sat = 1'b1;
                            else if (dir && occ == 0) sat = 1'b1;
                            else occ = dir ? occ - 1 : occ + 1;
                        end
                        exp_q.push_back(pack(av, bv, inc, dec, sat, 1'b1, 1'b0, 1'b0, occ));
                        occ_q.push_back(occ);
                    end
                end
                exp_q.push_back(pack('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, occ));
                occ_q.push_back(occ);
            end
        end
        exp_q.push_back(pack('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, occ));
        occ_q.push_back(occ);
    endtask

    // stop_kind: 0 run to completion, 1 async reset after trace[stop_at], 2 abort after trace[stop_at]
    task automatic run_cmd(input string name, input logic dir, input int gate, input int count,
                           input bit hold, input int stop_at, input int stop_kind);
        int n;
        @(negedge clk);
        bus_if.cmd_dir   = dir;
        bus_if.cmd_gate  = GW'(gate);
        bus_if.cmd_count = CW'(count);
        bus_if.cmd_valid = 1'b1;
        build_trace(dir, gate, count);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!hold || i == n - 1) bus_if.cmd_valid = 1'b0;
            check_value($sformatf("%s[%0d]", name, i), observed(), exp_q[i]);
            model_occ = occ_q[i];
            if (stop_kind != 0 && i == stop_at) break;
        end
        bus_if.cmd_valid = 1'b0;
        if (stop_kind == 1) begin
            rst_n = 1'b0;
            #1;
            model_occ = 0;
            check_value({name, "_async_rst"}, observed(), pack('0, '0, 0, 0, 0, 0, 0, 1, 0));
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check_value({name, "_post_rst"}, observed(), pack('0, '0, 0, 0, 0, 0, 0, 1, 0));
        end else if (stop_kind == 2) begin
`ifdef STIM_ABORT_EN
            bus_if.abort = 1'b1;
            @(negedge clk);
            bus_if.abort = 1'b0;
            check_value({name, "_abort"}, observed(), pack('0, '0, 0, 0, 0, 0, 1, 1, model_occ));
            @(negedge clk);
            check_value({name, "_abort_idle"}, observed(), pack('0, '0, 0, 0, 0, 0, 0, 1, model_occ));
`endif
        end else begin
            @(negedge clk);
            check_value({name, "_idle"}, observed(), pack('0, '0, 0, 0, 0, 0, 0, 1, model_occ));
        end
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_value({name, "_in_rst"}, observed(), pack('0, '0, 0, 0, 0, 0, 0, 1, 0));
        rst_n = 1'b1;
        model_occ = 0;
        @(negedge clk);
        check_value({name, "_rst_rel"}, observed(), pack('0, '0, 0, 0, 0, 0, 0, 1, 0));
    endtask

    initial begin
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_dir   = 1'b0;
        bus_if.cmd_gate  = '0;
        bus_if.cmd_count = '0;
`ifdef STIM_ABORT_EN
        bus_if.abort     = 1'b0;
`endif
        do_reset("reset0");

        run_cmd("enter5_g0", 1'b0, 0, 5, 1'b0, 0, 0);
        run_cmd("exit3_g1", 1'b1, 1, 3, 1'b0, 0, 0);
        check_value("occ_after_t2", 32'(bus_if.exp_occ), 32'd2);

        do_reset("reset3");
        run_cmd("enter17", 1'b0, 0, 17, 1'b0, 0, 0);
        check_value("occ_sat15", 32'(bus_if.exp_occ), 32'd15);

        do_reset("reset4");
        run_cmd("enter4", 1'b0, 1, 4, 1'b0, 0, 0);
        run_cmd("exit8", 1'b1, 0, 8, 1'b0, 0, 0);
        check_value("occ_floor0", 32'(bus_if.exp_occ), 32'd0);

        do_reset("reset5");
        run_cmd("rst_mid", 1'b0, 0, 5, 1'b0, 2 * CAR + DW, 1);

        run_cmd("hold_valid", 1'b0, 1, 3, 1'b1, 0, 0);
        run_cmd("count0", 1'b1, 0, 0, 1'b0, 0, 0);
        run_cmd("count0_hold", 1'b0, 1, 0, 1'b1, 0, 0);

`ifdef STIM_ABORT_EN
        run_cmd("abort_p3", 1'b0, 0, 3, 1'b0, CAR + 2 * DW, 2);
`endif

        for (int k = 0; k < 40; k++) begin
            run_cmd($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), int'($urandom_range(0, NG - 1)),
                    int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 0, 0);
        end

        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        model_occ = 0;
        check_value("soft_reset", observed(), pack('0, '0, 0, 0, 0, 0, 0, 1, 0));
        run_cmd("after_srst", 1'b0, 0, 2, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
